// File: rtl/sound_pkg.sv
// Shared constants for the piezo sound path: clock rate, duty codes and note periods.
package sound_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;

  // Duty code d gives a high time of period >> (d + 1).
  typedef enum logic [2:0] {
    DUTY_50 = 3'd0,
    DUTY_25 = 3'd1,
    DUTY_12 = 3'd2,
    DUTY_6  = 3'd3
  } duty_e;

  // Full tone periods in clocks.
  localparam int unsigned NOTE_C4 = CLK_HZ / 262;
  localparam int unsigned NOTE_D4 = CLK_HZ / 294;
  localparam int unsigned NOTE_E4 = CLK_HZ / 330;
  localparam int unsigned NOTE_F4 = CLK_HZ / 349;
  localparam int unsigned NOTE_G4 = CLK_HZ / 392;
  localparam int unsigned NOTE_A4 = CLK_HZ / 440;
  localparam int unsigned NOTE_B4 = CLK_HZ / 494;
  localparam int unsigned NOTE_C5 = CLK_HZ / 523;
  localparam int unsigned NOTE_D5 = CLK_HZ / 587;
  localparam int unsigned NOTE_E5 = CLK_HZ / 659;

  function automatic int unsigned ch_idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sound_mixer_nch_if.sv
// Request and status bundle between the sound sources and the N-channel mixer.
interface sound_mixer_nch_if #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned PERIOD_W = 20,
  parameter int unsigned DUR_W    = 25,
  parameter int unsigned DUTY_W   = 3
) ();

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]          ch_hold;
  logic [NUM_CH-1:0]          ch_trig;
  logic [NUM_CH*PERIOD_W-1:0] ch_period;
  logic [NUM_CH*DUTY_W-1:0]   ch_duty;
  logic [NUM_CH*DUR_W-1:0]    ch_dur;
  logic                       mute;
  logic                       piezo_out;
  logic [NUM_CH-1:0]          ch_active;
  logic [CH_W-1:0]            active_ch;
  logic                       any_active;

  modport master (
    output ch_hold, ch_trig, ch_period, ch_duty, ch_dur, mute,
    input  piezo_out, ch_active, active_ch, any_active
  );

  modport slave (
    input  ch_hold, ch_trig, ch_period, ch_duty, ch_dur, mute,
    output piezo_out, ch_active, active_ch, any_active
  );

endinterface

// File: rtl/tone_channel.sv
// One square-tone channel: one-shot/hold activity, phase counter with wrap-time
// period reload, and duty-shaped wave.
module tone_channel #(
  parameter int unsigned PERIOD_W = 20,
  parameter int unsigned DUR_W    = 25,
  parameter int unsigned DUTY_W   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hold,
  input  logic                trig,
  input  logic [PERIOD_W-1:0] period,
  input  logic [DUTY_W-1:0]   duty,
  input  logic [DUR_W-1:0]    dur,
  output logic                active,
  output logic                wave
);

  logic                active_q, active_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [PERIOD_W-1:0] high_time;
  logic [DUTY_W:0]     shamt;
  logic                fire;

  assign fire = trig & (dur != '0);

  always_comb begin
    active_d = hold | fire | (dur_q > DUR_W'(1));

    dur_d = dur_q;
    if (fire) begin
      dur_d = dur;
    end else if (dur_q != '0) begin
      dur_d = dur_q - DUR_W'(1);
    end

    cnt_d = '0;
    per_d = '0;
    if (active_d) begin
      // Period only reloads at phase start, wrap, or while resting, so tones never glitch.
      if (!active_q || (per_q == '0) || (cnt_q == per_q - PERIOD_W'(1))) begin
        per_d = period;
      end else begin
        cnt_d = cnt_q + PERIOD_W'(1);
        per_d = per_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      dur_q    <= '0;
      cnt_q    <= '0;
      per_q    <= '0;
    end else begin
      active_q <= active_d;
      dur_q    <= dur_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
    end
  end

  assign shamt     = {1'b0, duty} + {{DUTY_W{1'b0}}, 1'b1};
  assign high_time = per_q >> shamt;
  assign active    = active_q;
  assign wave      = active_q & (per_q != '0) & (cnt_q < high_time);

endmodule

// File: rtl/sound_mixer_nch.sv
// N-channel tone generator with fixed priority (channel 0 highest) onto a single
// registered piezo output.
module sound_mixer_nch #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned PERIOD_W = 20,
  parameter int unsigned DUR_W    = 25,
  parameter int unsigned DUTY_W   = 3
) (
  input  logic clk,
  input  logic rst_n,
  sound_mixer_nch_if.slave bus
);

  import sound_pkg::*;

  localparam int unsigned CH_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] act;
  logic [NUM_CH-1:0] wave;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   last_q;
  logic              piezo_q;
  logic              any;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tone_channel #(
      .PERIOD_W (PERIOD_W),
      .DUR_W    (DUR_W),
      .DUTY_W   (DUTY_W)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .hold   (bus.ch_hold[i]),
      .trig   (bus.ch_trig[i]),
      .period (bus.ch_period[i*PERIOD_W +: PERIOD_W]),
      .duty   (bus.ch_duty[i*DUTY_W +: DUTY_W]),
      .dur    (bus.ch_dur[i*DUR_W +: DUR_W]),
      .active (act[i]),
      .wave   (wave[i])
    );
  end

  // Scan from the top so the lowest active index wins.
  always_comb begin
    grant = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (act[i]) begin
        grant = CH_W'(i);
      end
    end
  end

  assign any = |act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      piezo_q <= 1'b0;
      last_q  <= '0;
    end else begin
      piezo_q <= any & wave[grant] & ~bus.mute;
      if (any) begin
        last_q <= grant;
      end
    end
  end

  assign bus.piezo_out  = piezo_q;
  assign bus.ch_active  = act;
  assign bus.active_ch  = any ? grant : last_q;
  assign bus.any_active = any;

endmodule
